panel_key_pulser: RTL and testbench
===================================

// Module: panel_key_pulser
// PURPOSE
//  Upstream Avalon master for the KA10 panel register block. Turns physical
//  operator pushbuttons (START, STOP, EXAMINE, DEPOSIT, ...) into momentary
//  key presses at the panel's key registers.
//  Each debounced press becomes a SET write to 6'o00, a hold of HOLD_CYCLES,
//  then a CLR write to 6'o01.
//  Sits beside the HPS bridge in front of the panel slave, through the system
//  interconnect arbiter.
// PARAMETERS
//  NKEYS       20   buttons; bit i maps to key register bit i (0=DEP NXT .. 19=SING INST)
//  DEB_TICK    5000 clk cycles per debounce sample tick (>=2)
//  HOLD_CYCLES 64   cycles between SET write accepted and CLR write issued (>=1)
// PORTS
//  clk            in   1      system clock
//  reset          in   1      synchronous, active-high reset
//  btn            in   NKEYS  raw pushbuttons, asynchronous, 1=pressed
//  m_address      out  6      Avalon master address (word, octal register map)
//  m_write        out  1      Avalon write strobe
//  m_read         out  1      Avalon read strobe (PANEL_KEY_READBACK_EN only, else 0)
//  m_writedata    out  32     key mask in [NKEYS-1:0], upper bits 0
//  m_readdata     in   32     read data (used only with readback)
//  m_waitrequest  in   1      slave stall; transfer completes on a cycle it is low
//  busy           out  1      FSM not in IDLE
//  pending        out  NKEYS  presses captured, not yet issued
//  err            out  1      sticky readback mismatch (0 without feature)
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-high.
//  Reset values:
//   - all outputs 0; FSM in IDLE; pending, counters and samples cleared.
//   - Reset mid-transfer abandons it and issues no CLR write. Panel keys left
//     set stay set until cleared by host or panel reset.
//  Synchronizer: btn passes through a 2-flop synchronizer.
//  Debounce:
//   - Shared prescaler pulses tick every DEB_TICK cycles.
//   - Per bit, a 3-sample shift register.
//   - Stable level changes only when all 3 samples agree.
//   - Rising edge of the stable level ORs that bit into pending.
//   - Releases are ignored. Minimum press-to-pending latency is 3 ticks + 2 cycles.
//  FSM states: IDLE -> SET -> HOLD -> CLR [-> RDBK] -> IDLE.
//  IDLE:
//   - If pending != 0: cur <= pending, pending <= 0 (same cycle), go to SET.
//   - A debounce edge in that same cycle lands in pending, never lost.
//  SET:
//   - m_write=1, m_address=6'o00, m_writedata=cur.
//   - Held stable while m_waitrequest=1. Leave on the first cycle it is 0.
//  HOLD:
//   - Down-counter loaded with HOLD_CYCLES-1; go to CLR when it reaches 0.
//   - Presses during SET/HOLD/CLR/RDBK accumulate in pending only, never in cur.
//  CLR: m_write=1, m_address=6'o01, m_writedata=cur, same handshake as SET.
//  Repeats: pressing a key already in cur yields a second full pulse after the
//   current one; never merged.
//  m_write and m_read are mutually exclusive; at most one outstanding transfer.
//  Back-to-back: IDLE to SET re-entry costs 1 cycle. Bus occupancy per pulse is
//   2 transfers plus HOLD.
// CONFIGURATION
//  PANEL_KEY_READBACK_EN defined:
//   - After CLR, enter RDBK: m_read=1, m_address=6'o00.
//   - On the cycle with m_waitrequest=0, sample m_readdata.
//   - If (m_readdata[NKEYS-1:0] & cur) != 0, set err (sticky until reset).
//   - Then go to IDLE.
//  Not defined: no RDBK state, m_read tied 0, err tied 0.
// STRUCTURE
//  panel_ka_pkg holds:
//   - REG_KEY_SET=6'o00, REG_KEY_CLR=6'o01, key bit index localparams
//     (KEY_DEP_NXT=0 .. KEY_SING_INST=19)
//   - the state enum
//  Sub-module key_debounce (one bit): sync and 3-sample stable/edge logic.
//   Instantiated NKEYS times via generate; the tick is a shared input.
//  Top level: prescaler, pending register, FSM, Avalon drive.
// TESTING
//  All tests run with DEB_TICK=4 and HOLD_CYCLES=8; the slave model has
//  programmable waitrequest.
//  1 Basic pulse:
//    btn[8] (STA) high 40 cycles -> SET write 6'o00 data 32'h100.
//    CLR write 6'o01 data 32'h100 exactly 8 cycles after SET accept; busy
//    falls after.
//  2 Glitch reject:
//    btn[6] high 6 cycles (< 3 ticks) -> no transfer, pending stays 0.
//  3 Merge and queue:
//    btn[3] pressed; btn[1] pressed during HOLD -> first pulse mask 32'h8.
//    Then a second SET/CLR pair mask 32'h2 with no gap beyond 1 IDLE cycle.
//  4 Waitrequest:
//    slave holds waitrequest 5 cycles on SET -> address and data stable
//    throughout; HOLD count starts at acceptance.
//  5 Reset mid-HOLD:
//    reset asserted 1 cycle -> next cycle all outputs 0, no CLR write;
//    btn held stays ignored until released and re-pressed.
//  6 Readback (PANEL_KEY_READBACK_EN):
//    slave returns bit 8 still set -> err=1 and sticky; correct readback keeps
//    err=0.

Source files
------------

// File: rtl/panel_ka_pkg.sv
// Shared definitions for the KA10 panel key pulser.
//   REG_KEY_SET / REG_KEY_CLR : word addresses of the panel key set/clear registers
//   KEY_*                     : bit index of each operator key in the key mask
//   state_e                   : pulser FSM states (ST_RDBK only reachable when the
//                               PANEL_KEY_READBACK_EN build option is defined)
package panel_ka_pkg;

    localparam logic [5:0] REG_KEY_SET = 6'o00;
    localparam logic [5:0] REG_KEY_CLR = 6'o01;

    localparam int KEY_DEP_NXT     = 0;
    localparam int KEY_DEP_THIS    = 1;
    localparam int KEY_EXA_NXT     = 2;
    localparam int KEY_EXA_THIS    = 3;
    localparam int KEY_XCT         = 4;
    localparam int KEY_IO_RESET    = 5;
    localparam int KEY_STOP        = 6;
    localparam int KEY_CONT        = 7;
    localparam int KEY_STA         = 8;
    localparam int KEY_READ_IN     = 9;
    localparam int KEY_ADR_BRK     = 10;
    localparam int KEY_ADR_INST    = 11;
    localparam int KEY_ADR_RD      = 12;
    localparam int KEY_ADR_WR      = 13;
    localparam int KEY_PAR_STOP    = 14;
    localparam int KEY_NXM_STOP    = 15;
    localparam int KEY_REPT        = 16;
    localparam int KEY_MI_PROG_DIS = 17;
    localparam int KEY_SING_CYC    = 18;
    localparam int KEY_SING_INST   = 19;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET,
        ST_HOLD,
        ST_CLR,
        ST_RDBK
    } state_e;

endpackage

// File: rtl/panel_key_pulser_debounce.sv
// key_debounce: one pushbutton bit -> synchronised, debounced rising-edge pulse.
//   clk     : system clock
//   reset   : synchronous, active-high
//   tick_i  : shared debounce sample strobe (one cycle wide)
//   btn_i   : raw asynchronous button, 1 = pressed
//   rise_o  : one-cycle pulse when the debounced level goes 0 -> 1
module key_debounce (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic btn_i,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic [2:0] samp_q;
    logic [2:0] samp_d;
    logic       stable_q;
    logic       all_one;
    logic       all_zero;

    // NOTE: every signal written in always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        samp_d = {samp_q[1:0], sync_q[1]};
    end

    assign all_one  = &samp_d;
    assign all_zero = ~|samp_d;
    assign rise_o   = tick_i & all_one & ~stable_q;

    // The stable level comes out of reset as "pressed": a button held through
    // reset can then never produce an edge until it has been seen released.
    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            samp_q   <= '0;
            stable_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            if (tick_i) begin
                samp_q <= samp_d;
                if (all_one) begin
                    stable_q <= 1'b1;
                end else if (all_zero) begin
                    stable_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/panel_key_pulser.sv
// panel_key_pulser: Avalon master turning debounced operator pushbuttons into
// momentary key presses (SET write, hold, CLR write) at the KA10 panel registers.
// Build option: PANEL_KEY_READBACK_EN adds a read-back of the SET register after
// the CLR write and a sticky err flag when any key of the pulse is still set.
//   clk, reset      : system clock, synchronous active-high reset
//   btn             : raw pushbuttons, 1 = pressed
//   m_address       : Avalon word address
//   m_write/m_read  : Avalon strobes (m_read is 0 without the build option)
//   m_writedata     : key mask, upper bits 0
//   m_readdata      : read data (read-back build only)
//   m_waitrequest   : slave stall
//   busy            : FSM not idle
//   pending         : captured presses not yet issued
//   err             : sticky read-back mismatch (0 without the build option)
module panel_key_pulser
    import panel_ka_pkg::*;
#(
    parameter int NKEYS       = 20,
    parameter int DEB_TICK    = 5000,
    parameter int HOLD_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] btn,
    output logic [5:0]       m_address,
    output logic             m_write,
    output logic             m_read,
    output logic [31:0]      m_writedata,
    input  logic [31:0]      m_readdata,
    input  logic             m_waitrequest,
    output logic             busy,
    output logic [NKEYS-1:0] pending,
    output logic             err
);

    localparam int PW = $clog2(DEB_TICK);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DEB_TICK - 1);

    logic [PW-1:0]    presc_q;
    logic             tick_q;
    logic [NKEYS-1:0] rise;
    logic [NKEYS-1:0] pending_q;
    logic [NKEYS-1:0] pending_d;
    logic             take;

    state_e           state_q;
    logic [NKEYS-1:0] cur_q;
    logic [HW-1:0]    hold_q;
    logic [5:0]       addr_q;
    logic             wr_q;
    logic [31:0]      wdata_q;
    logic             busy_q;

    // Registered tick: the first sample lands after the synchronisers have
    // already refilled following reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q  <= (presc_q == PRESC_LAST);
            presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        end
    end

    for (genvar i = 0; i < NKEYS; i++) begin : g_deb
        key_debounce u_deb (
            .clk    (clk),
            .reset  (reset),
            .tick_i (tick_q),
            .btn_i  (btn[i]),
            .rise_o (rise[i])
        );
    end

    // Capture and new edges share a cycle: clear first, then OR in the edges.
    assign take = (state_q == ST_IDLE) && (pending_q != '0);

    always_comb begin
        pending_d = (take ? '0 : pending_q) | rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

`ifdef PANEL_KEY_READBACK_EN
    logic rd_q;
    logic err_q;
`endif

    // Reset abandons any transfer in flight; keys already set on the panel
    // stay set until the host or a panel reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            hold_q  <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
`ifdef PANEL_KEY_READBACK_EN
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take) begin
                        cur_q   <= pending_q;
                        wr_q    <= 1'b1;
                        addr_q  <= REG_KEY_SET;
                        wdata_q <= 32'(pending_q);
                        busy_q  <= 1'b1;
                        state_q <= ST_SET;
                    end
                end
                ST_SET: begin
                    if (!m_waitrequest) begin
                        wr_q    <= 1'b0;
                        hold_q  <= HW'(HOLD_CYCLES - 1);
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_q == '0) begin
                        wr_q    <= 1'b1;
                        addr_q  <= REG_KEY_CLR;
                        wdata_q <= 32'(cur_q);
                        state_q <= ST_CLR;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                ST_CLR: begin
                    if (!m_waitrequest) begin
                        wr_q <= 1'b0;
`ifdef PANEL_KEY_READBACK_EN
                        rd_q    <= 1'b1;
                        addr_q  <= REG_KEY_SET;
                        wdata_q <= '0;
                        state_q <= ST_RDBK;
`else
                        addr_q  <= '0;
                        wdata_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
`endif
                    end
                end
`ifdef PANEL_KEY_READBACK_EN
                ST_RDBK: begin
                    if (!m_waitrequest) begin
                        rd_q    <= 1'b0;
                        addr_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                        if ((m_readdata[NKEYS-1:0] & cur_q) != '0) begin
                            err_q <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    wr_q    <= 1'b0;
                    addr_q  <= '0;
                    wdata_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_address   = addr_q;
    assign m_write     = wr_q;
    assign m_writedata = wdata_q;
    assign busy        = busy_q;
    assign pending     = pending_q;

`ifdef PANEL_KEY_READBACK_EN
    assign m_read = rd_q;
    assign err    = err_q;
`else
    assign m_read = 1'b0;
    assign err    = 1'b0;
`endif

    // Upper read-data bits (and all of it without read-back) carry nothing.
    logic unused_rd;
    assign unused_rd = ^m_readdata;

endmodule

// File: tb/tb_panel_key_pulser.sv
// Self-checking bench for panel_key_pulser (DEB_TICK=4, HOLD_CYCLES=8).
// Directed scenarios followed by randomised presses; a scoreboard counts
// debounced presses per key and compares against the keys seen in SET writes.
module tb_panel_key_pulser;
    import panel_ka_pkg::*;

    localparam int NKEYS = 20;
    localparam int DEB   = 4;
    localparam int HOLD  = 8;
`ifdef PANEL_KEY_READBACK_EN
    localparam int XPP = 3;
`else
    localparam int XPP = 2;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NKEYS-1:0] btn = '0;
    logic [5:0]       m_address;
    logic             m_write;
    logic             m_read;
    logic [31:0]      m_writedata;
    logic [31:0]      rd_data = '0;
    logic             m_waitrequest;
    logic             busy;
    logic [NKEYS-1:0] pending;
    logic             err;

    panel_key_pulser #(.NKEYS(NKEYS), .DEB_TICK(DEB), .HOLD_CYCLES(HOLD)) dut (
        .clk           (clk),
        .reset         (reset),
        .btn           (btn),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_read        (m_read),
        .m_writedata   (m_writedata),
        .m_readdata    (rd_data),
        .m_waitrequest (m_waitrequest),
        .busy          (busy),
        .pending       (pending),
        .err           (err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave model: each transfer stalls wait_now cycles (random 0..3 when wait_mode < 0).
    int wait_mode = 0;
    int rnd_wait  = 0;
    int stall_cnt = 0;
    int wait_now;

    always_comb begin
        wait_now      = (wait_mode < 0) ? rnd_wait : wait_mode;
        m_waitrequest = (m_write || m_read) && (stall_cnt < wait_now);
    end

    always @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 0;
        end else if ((m_write || m_read) && !m_waitrequest) begin
            stall_cnt <= 0;
            rnd_wait  <= $urandom_range(0, 3);
        end else if (m_write || m_read) begin
            stall_cnt <= stall_cnt + 1;
        end
    end

    // Transfer monitor: issue = edge the strobe appeared, acc = edge it completed.
    typedef struct {
        int          issue;
        int          acc;
        logic [5:0]  addr;
        logic [31:0] data;
        logic        rd;
    } xfer_t;

    typedef struct {
        logic [31:0] mask;
        int          set_issue;
        int          set_stall;
        int          last_acc;
    } pulse_t;

    xfer_t  log_q[$];
    pulse_t pulses[$];

    logic        in_xfer = 1'b0;
    int          x_issue = 0;
    logic [5:0]  x_addr  = '0;
    logic [31:0] x_data  = '0;
    logic        x_rd    = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            in_xfer = 1'b0;
        end else if (m_write || m_read) begin
            if (!in_xfer) begin
                in_xfer = 1'b1;
                x_issue = cyc;
                x_addr  = m_address;
                x_data  = m_writedata;
                x_rd    = m_read;
            end else begin
                check("stall_addr_stable", 32'(m_address), 32'(x_addr));
                check("stall_data_stable", m_writedata, x_data);
            end
            check("wr_rd_exclusive", 32'(m_write & m_read), 32'd0);
            if (!m_waitrequest) begin
                log_q.push_back('{x_issue, cyc + 1, x_addr, x_data, x_rd});
                in_xfer = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_quiet();
        int q;
        int t;
        q = 0;
        t = 0;
        while (q < 30 && t < 3000) begin
            step(1);
            t++;
            if (!busy && pending == '0) q++;
            else q = 0;
        end
        check("quiet_reached", 32'(q >= 30), 32'd1);
    endtask

    task automatic wait_log(input int n);
        int t;
        t = 0;
        while (log_q.size() < n && t < 500) begin
            step(1);
            t++;
        end
        check("log_wait", 32'(log_q.size() >= n), 32'd1);
    endtask

    task automatic press(input int key, input int n);
        btn[key] = 1'b1;
        step(n);
        btn[key] = 1'b0;
    endtask

    // Split the log into pulses and check every pulse's protocol shape.
    task automatic scan_log();
        int     i;
        xfer_t  s;
        xfer_t  c;
        pulse_t p;
        pulses.delete();
        i = 0;
        while (i < log_q.size()) begin
            if (i + XPP > log_q.size()) begin
                check("log_whole_pulses", 32'(log_q.size()), 32'(i + XPP));
                break;
            end
            s = log_q[i];
            c = log_q[i + 1];
            check("set_is_write", 32'(s.rd), 32'd0);
            check("set_addr", 32'(s.addr), 32'(REG_KEY_SET));
            check("set_mask_nonzero", 32'(s.data != 0), 32'd1);
            check("set_upper_zero", s.data >> NKEYS, 32'd0);
            check("clr_is_write", 32'(c.rd), 32'd0);
            check("clr_addr", 32'(c.addr), 32'(REG_KEY_CLR));
            check("clr_data", c.data, s.data);
            check("hold_gap", 32'(c.issue - s.acc), 32'(HOLD));
            p.mask      = s.data;
            p.set_issue = s.issue;
            p.set_stall = s.acc - s.issue;
            p.last_acc  = c.acc;
`ifdef PANEL_KEY_READBACK_EN
            check("rdbk_is_read", 32'(log_q[i + 2].rd), 32'd1);
            check("rdbk_addr", 32'(log_q[i + 2].addr), 32'(REG_KEY_SET));
            check("rdbk_follows_clr", 32'(log_q[i + 2].issue), 32'(c.acc));
            p.last_acc = log_q[i + 2].acc;
`endif
            pulses.push_back(p);
            i += XPP;
        end
    endtask

    int exp_cnt[NKEYS];
    int obs_cnt[NKEYS];
    int dur[NKEYS];

    initial begin
        int nk;
        int k;

        // Reset state
        step(3);
        check("rst_strobes", {28'd0, m_write, m_read, busy, err}, 32'd0);
        check("rst_address", 32'(m_address), 32'd0);
        check("rst_wdata", m_writedata, 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        reset = 1'b0;
        step(12);

        // 1: basic pulse on STA
        log_q.delete();
        btn[KEY_STA] = 1'b1;
        wait_log(1);
        check("t1_busy_during", 32'(busy), 32'd1);
        step(30);
        btn[KEY_STA] = 1'b0;
        wait_quiet();
        scan_log();
        check("t1_pulse_count", 32'(pulses.size()), 32'd1);
        if (pulses.size() > 0) check("t1_mask", pulses[0].mask, 32'h100);
        check("t1_busy_after", 32'(busy), 32'd0);

        // 2: glitch shorter than three ticks is rejected
        log_q.delete();
        press(KEY_STOP, 6);
        wait_quiet();
        check("t2_no_transfer", 32'(log_q.size()), 32'd0);
        check("t2_pending", 32'(pending), 32'd0);

        // 3: press during a pulse queues a second pulse, not merged
        log_q.delete();
        wait_mode = 20;
        btn[KEY_EXA_THIS] = 1'b1;
        wait_log(1);
        btn[KEY_EXA_THIS] = 1'b0;
        btn[KEY_DEP_THIS] = 1'b1;
        step(40);
        btn[KEY_DEP_THIS] = 1'b0;
        wait_quiet();
        scan_log();
        check("t3_pulse_count", 32'(pulses.size()), 32'd2);
        if (pulses.size() == 2) begin
            check("t3_first_mask", pulses[0].mask, 32'h8);
            check("t3_second_mask", pulses[1].mask, 32'h2);
            check("t3_idle_gap", 32'(pulses[1].set_issue - pulses[0].last_acc), 32'd1);
        end

        // 4: waitrequest stall on SET; hold counts from acceptance
        log_q.delete();
        wait_mode = 5;
        press(KEY_EXA_NXT, 40);
        wait_quiet();
        scan_log();
        check("t4_pulse_count", 32'(pulses.size()), 32'd1);
        if (pulses.size() > 0) begin
            check("t4_mask", pulses[0].mask, 32'h4);
            check("t4_set_stall", 32'(pulses[0].set_stall), 32'd6);
        end

        // 5: reset during HOLD drops the CLR; held button stays ignored
        log_q.delete();
        wait_mode = 0;
        btn[KEY_STA] = 1'b1;
        wait_log(1);
        step(3);
        reset = 1'b1;
        step(1);
        check("t5_rst_strobes", {28'd0, m_write, m_read, busy, err}, 32'd0);
        check("t5_rst_address", 32'(m_address), 32'd0);
        check("t5_rst_wdata", m_writedata, 32'd0);
        reset = 1'b0;
        step(60);
        check("t5_no_clr", 32'(log_q.size()), 32'd1);
        check("t5_held_ignored", 32'(pending), 32'd0);
        btn[KEY_STA] = 1'b0;
        wait_quiet();
        check("t5_still_one", 32'(log_q.size()), 32'd1);
        log_q.delete();
        press(KEY_STA, 40);
        wait_quiet();
        scan_log();
        check("t5_repress_count", 32'(pulses.size()), 32'd1);
        if (pulses.size() > 0) check("t5_repress_mask", pulses[0].mask, 32'h100);

`ifdef PANEL_KEY_READBACK_EN
        // 6: read-back mismatch sets a sticky err
        rd_data = 32'h200;
        press(KEY_STA, 40);
        wait_quiet();
        check("t6_clean_readback", 32'(err), 32'd0);
        rd_data = 32'h100;
        press(KEY_STA, 40);
        wait_quiet();
        check("t6_stuck_key", 32'(err), 32'd1);
        rd_data = 32'h0;
        press(KEY_STA, 40);
        wait_quiet();
        check("t6_err_sticky", 32'(err), 32'd1);
`else
        check("t6_err_tied", 32'(err), 32'd0);
`endif

        // Random presses: long presses must each yield one SET, glitches none.
        log_q.delete();
        wait_mode = -1;
        for (int i = 0; i < NKEYS; i++) begin
            exp_cnt[i] = 0;
            obs_cnt[i] = 0;
        end
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < NKEYS; i++) dur[i] = 0;
            nk = $urandom_range(1, 3);
            for (int j = 0; j < nk; j++) begin
                k = $urandom_range(0, NKEYS - 1);
                dur[k] = ($urandom_range(0, 1) == 1) ? 40 : $urandom_range(1, 6);
            end
            for (int i = 0; i < NKEYS; i++) if (dur[i] >= 40) exp_cnt[i]++;
            for (int t = 0; t < 44; t++) begin
                for (int i = 0; i < NKEYS; i++) btn[i] = (t < dur[i]);
                step(1);
            end
            btn = '0;
            wait_quiet();
        end
        scan_log();
        foreach (pulses[p]) begin
            for (int i = 0; i < NKEYS; i++) if (pulses[p].mask[i]) obs_cnt[i]++;
        end
        for (int i = 0; i < NKEYS; i++) check($sformatf("rand_key%0d_count", i), 32'(obs_cnt[i]), 32'(exp_cnt[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
